// File: rtl/cpc_lowrom_pager_if.sv
// CPC low-ROM pager bus bundle.
// Z80 strobes and jumper in, ROM select/enable/bank out.
interface cpc_lowrom_pager_if #(
  parameter int BANK_BITS = 2
);
  logic [15:0]          A;
  logic [7:0]           D;
  logic                 MREQ_B;
  logic                 IOREQ_B;
  logic                 WR_B;
  logic                 ROMEN_B;
  logic                 disable_j;
  logic                 romcs_b;
  logic                 ROMDIS;
  logic                 rom_we_b;
  logic [BANK_BITS-1:0] rom_bank;

  modport master (
    output A, D, MREQ_B, IOREQ_B, WR_B,
    output ROMEN_B, disable_j,
    input  romcs_b, ROMDIS, rom_we_b, rom_bank
  );

  modport slave (
    input  A, D, MREQ_B, IOREQ_B, WR_B,
    input  ROMEN_B, disable_j,
    output romcs_b, ROMDIS, rom_we_b, rom_bank
  );
endinterface

// File: rtl/cpc_lowrom_pager.sv
// CPC low-ROM pager: I/O-mapped bank/enable register.
// Replaces the internal low ROM with a paged flash.
module cpc_lowrom_pager #(
  parameter int       NUM_BANKS = 4,
  parameter bit [7:0] PORT_HI   = 8'hFC,
  parameter bit       RESET_EN  = 1'b1
) (
  input logic CLK,
  input logic RESET_B,
  cpc_lowrom_pager_if.slave bus
);
  localparam int BANK_BITS =
    (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                 q;
  logic                 q1;
  logic                 q2;
  logic                 wp;
  logic                 en;
  logic                 we;
  logic                 lock;
  logic [BANK_BITS-1:0] bank;
  logic                 low;
  logic                 dis;
  logic                 unused_bits;

  assign dis = bus.disable_j;
  assign low = !bus.A[15] && !bus.A[14];

  // I/O write to the control port, A[7:1] ignored
  assign q = !bus.IOREQ_B && !bus.WR_B &&
             (bus.A[15:8] == PORT_HI) && !bus.A[0];

  // one pulse per strobe, however long it is held
  assign wp = q1 && !q2;

  assign unused_bits = ^{bus.A[7:1], bus.D};

  // strobe synchroniser / edge history
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= q;
      q2 <= q1;
    end
  end

  // control register; frozen once lock is set
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      en   <= RESET_EN;
      we   <= 1'b0;
      lock <= 1'b0;
      bank <= '0;
    end else if (wp && !lock) begin
      en   <= bus.D[7];
      we   <= bus.D[6];
      lock <= bus.D[5];
      bank <= bus.D[BANK_BITS-1:0];
    end
  end

  // ROM decode; jumper forces everything off
  always_comb begin
    bus.romcs_b  = bus.ROMEN_B || !low || !en || dis;
    bus.ROMDIS   = low && en && !dis;
    bus.rom_we_b = bus.MREQ_B || bus.WR_B || !low ||
                   !we || !en || lock || dis;
    bus.rom_bank = bank;
  end
endmodule

// File: tb/tb_cpc_lowrom_pager.sv
// Bench for cpc_lowrom_pager: directed cases plus
// random bus traffic against a behavioural model.
module tb_cpc_lowrom_pager;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  cpc_lowrom_pager_if #(.BANK_BITS(2)) bus ();

  cpc_lowrom_pager #(
    .NUM_BANKS(4),
    .PORT_HI(8'hFC),
    .RESET_EN(1'b1)
  ) dut (
    .CLK(clk),
    .RESET_B(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // model state: the register as software sees it
  bit       m_en = 1'b1;
  bit       m_we = 1'b0;
  bit       m_lock = 1'b0;
  bit [1:0] m_bank = 2'd0;
  bit       qs[$];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit port_write();
    return !bus.IOREQ_B && !bus.WR_B &&
           bus.A[15:8] == 8'hFC && !bus.A[0];
  endfunction

  // model: an I/O write seen at edge n-1 but not n-2
  // is taken at edge n, with D as it is at edge n
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_en = 1'b1;
      m_we = 1'b0;
      m_lock = 1'b0;
      m_bank = 2'd0;
      qs.delete();
    end else begin
      if (qs.size() >= 1 && qs[qs.size()-1] &&
          (qs.size() < 2 || !qs[qs.size()-2]) &&
          !m_lock) begin
        m_en = bus.D[7];
        m_we = bus.D[6];
        m_lock = bus.D[5];
        m_bank = bus.D[1:0];
      end
      qs.push_back(port_write());
      if (qs.size() > 4) void'(qs.pop_front());
    end
  end

  // every-cycle compare against the model
  initial forever begin
    bit low;
    bit e_cs;
    bit e_dis;
    bit e_we;
    @(negedge clk);
    low = bus.A < 16'h4000;
    e_dis = low && m_en && !bus.disable_j;
    e_cs = !(e_dis && !bus.ROMEN_B);
    e_we = !(!bus.MREQ_B && !bus.WR_B && low &&
             m_we && m_en && !m_lock && !bus.disable_j);
    chk("model romcs_b", 16'(bus.romcs_b), 16'(e_cs));
    chk("model ROMDIS", 16'(bus.ROMDIS), 16'(e_dis));
    chk("model rom_we_b", 16'(bus.rom_we_b), 16'(e_we));
    chk("model rom_bank", 16'(bus.rom_bank), 16'(m_bank));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MREQ_B = 1'b1;
    bus.IOREQ_B = 1'b1;
    bus.WR_B = 1'b1;
    bus.ROMEN_B = 1'b1;
  endtask

  task automatic io_write(input logic [15:0] addr,
                          input logic [7:0] data,
                          input int len);
    idle();
    bus.A = addr;
    bus.D = data;
    bus.IOREQ_B = 1'b0;
    bus.WR_B = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == 2) bus.D = ~data;
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic rd_chk(input string name,
                        input logic [15:0] addr,
                        input logic cs, input logic dis,
                        input logic [1:0] bank);
    idle();
    bus.A = addr;
    bus.MREQ_B = 1'b0;
    bus.ROMEN_B = 1'b0;
    @(negedge clk);
    chk({name, " romcs_b"}, 16'(bus.romcs_b), 16'(cs));
    chk({name, " ROMDIS"}, 16'(bus.ROMDIS), 16'(dis));
    chk({name, " rom_bank"}, 16'(bus.rom_bank), 16'(bank));
    step();
    idle();
  endtask

  task automatic wr_chk(input string name,
                        input logic [15:0] addr,
                        input logic web,
                        input logic [1:0] bank);
    idle();
    bus.A = addr;
    bus.MREQ_B = 1'b0;
    bus.WR_B = 1'b0;
    @(negedge clk);
    chk({name, " rom_we_b"}, 16'(bus.rom_we_b), 16'(web));
    chk({name, " rom_bank"}, 16'(bus.rom_bank), 16'(bank));
    step();
    idle();
  endtask

  initial begin
    idle();
    bus.A = 16'h1234;
    bus.D = 8'h00;
    bus.disable_j = 1'b0;
    bus.MREQ_B = 1'b0;
    bus.ROMEN_B = 1'b0;
    @(negedge clk);
    chk("rst romcs_b", 16'(bus.romcs_b), 16'd0);
    chk("rst ROMDIS", 16'(bus.ROMDIS), 16'd1);
    chk("rst rom_bank", 16'(bus.rom_bank), 16'd0);
    chk("rst rom_we_b", 16'(bus.rom_we_b), 16'd1);
    step();
    rst_n = 1'b1;
    rd_chk("post-rst", 16'h1234, 1'b0, 1'b1, 2'd0);

    // held OUT &FC00,&83: one capture, one edge after q1
    idle();
    bus.A = 16'hFC00;
    bus.D = 8'h83;
    bus.IOREQ_B = 1'b0;
    bus.WR_B = 1'b0;
    @(negedge clk);
    chk("out83 before", 16'(bus.rom_bank), 16'd0);
    step();
    @(negedge clk);
    chk("out83 q1 edge", 16'(bus.rom_bank), 16'd0);
    step();
    @(negedge clk);
    chk("out83 capture", 16'(bus.rom_bank), 16'd3);
    bus.D = 8'h7C;
    step();
    step();
    idle();
    step();
    rd_chk("out83 4000", 16'h4000, 1'b1, 1'b0, 2'd3);
    rd_chk("out83 0000", 16'h0000, 1'b0, 1'b1, 2'd3);

    io_write(16'hFC00, 8'hC1, 3);
    wr_chk("flash 2000", 16'h2000, 1'b0, 2'd1);
    wr_chk("flash 8000", 16'h8000, 1'b1, 2'd1);

    io_write(16'hFC00, 8'hA2, 2);
    io_write(16'hFC00, 8'h80, 2);
    wr_chk("locked", 16'h2000, 1'b1, 2'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd_chk("unlock rst", 16'h0000, 1'b0, 1'b1, 2'd0);

    bus.disable_j = 1'b1;
    io_write(16'hFC00, 8'h81, 2);
    rd_chk("jumper off", 16'h0000, 1'b1, 1'b0, 2'd1);
    bus.disable_j = 1'b0;
    rd_chk("jumper on", 16'h0000, 1'b0, 1'b1, 2'd1);

    io_write(16'hFD00, 8'h82, 3);
    io_write(16'hFC01, 8'h82, 3);
    rd_chk("bad port", 16'h0000, 1'b0, 1'b1, 2'd1);
    io_write(16'hFCFE, 8'h82, 2);
    rd_chk("A7:1 ignored", 16'h0000, 1'b0, 1'b1, 2'd2);

    // reset in the middle of an I/O write
    idle();
    bus.A = 16'hFC00;
    bus.D = 8'h83;
    bus.IOREQ_B = 1'b0;
    bus.WR_B = 1'b0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-rst bank", 16'(bus.rom_bank), 16'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst-release cap", 16'(bus.rom_bank), 16'd3);
    idle();
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst_n = ($urandom_range(0, 249) != 0);
      r = $urandom_range(0, 3);
      case (r)
        0: bus.A = {8'hFC, 7'($urandom), 1'b0};
        1: bus.A = {8'hFC, 7'($urandom), 1'b1};
        2: bus.A = {2'b00, 14'($urandom)};
        default: bus.A = 16'($urandom);
      endcase
      bus.D = 8'($urandom) &
              (($urandom_range(0, 7) == 0) ? 8'hFF : 8'hDF);
      if ($urandom_range(0, 2) == 0) begin
        bus.IOREQ_B = 1'($urandom);
        bus.WR_B = 1'($urandom);
        bus.MREQ_B = 1'($urandom);
        bus.ROMEN_B = 1'($urandom);
      end
      bus.disable_j = ($urandom_range(0, 15) == 0);
      step();
    end

    rst_n = 1'b1;
    idle();
    step();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
